biquad_coef_loader: RTL and testbench

//   Configuration front end for the cascaded biquad filter. Receives coefficient frames as a

---
 rtl/biquad_coef_loader.sv | 157 +++++++++++++++
 tb/tb_biquad_coef_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_coef_loader.sv
// Byte-stream coefficient loader for a cascaded biquad: parses A5/IDX/10 coef bytes/CHK frames
// and commits all five coefficients of one section in a single cycle.
module biquad_coef_loader #(
    parameter int unsigned N_SECT   = 4,
    parameter logic [15:0] COEF_ONE = 16'h4000,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [16*N_SECT-1:0]  b_0,
    output logic [16*N_SECT-1:0]  b_1,
    output logic [16*N_SECT-1:0]  b_2,
    output logic [16*N_SECT-1:0]  a_1,
    output logic [16*N_SECT-1:0]  a_2,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned W  = 16 * N_SECT;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StIndex, StData, StCheck, StCommit} state_e;

    state_e          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [79:0]     stage_q, stage_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [W-1:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
    logic            ok_q, ok_d, err_q, err_d;
    logic            xfer;
    logic            idx_ok;

    assign in_ready  = (state_q != StCommit);
    assign busy      = (state_q != StIdle);
    assign xfer      = in_valid && in_ready;
    assign idx_ok    = 32'(idx_q) < N_SECT;
    assign b_0       = b0_q;
    assign b_1       = b1_q;
    assign b_2       = b2_q;
    assign a_1       = a1_q;
    assign a_2       = a2_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        idle_d  = '0;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer && in_data == 8'hA5) state_d = StIndex;
            end
            StIndex: begin
                if (xfer) begin
                    idx_d   = in_data;
                    chk_d   = in_data;
                    cnt_d   = 4'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (xfer) begin
                    stage_d = {stage_q[71:0], in_data};
                    chk_d   = chk_q ^ in_data;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd9) state_d = StCheck;
                end
            end
            StCheck: begin
                if (xfer) begin
                    if (in_data == chk_q && idx_ok) begin
                        state_d = StCommit;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StCommit: begin
                for (int k = 0; k < N_SECT; k++) begin
                    if (idx_q == 8'(k)) begin
                        b0_d[16*k +: 16] = stage_q[79:64];
                        b1_d[16*k +: 16] = stage_q[63:48];
                        b2_d[16*k +: 16] = stage_q[47:32];
                        a1_d[16*k +: 16] = stage_q[31:16];
                        a2_d[16*k +: 16] = stage_q[15:0];
                    end
                end
                ok_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte watchdog, only while a frame is in flight.
        if (state_q == StIndex || state_q == StData || state_q == StCheck) begin
            if (xfer) begin
                idle_d = '0;
            end else if (idle_q == TW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            chk_q   <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            idle_q  <= '0;
            b0_q    <= {N_SECT{COEF_ONE}};
            b1_q    <= '0;
            b2_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            idle_q  <= idle_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Scoreboard bench for biquad_coef_loader: frame-level reference model of the coefficient bank,
// expected outcomes queued by the driver and checked by an independent pulse monitor.
module tb_biquad_coef_loader;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned W  = 16 * N;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  b_0, b_1, b_2, a_1, a_2;
    logic          frame_ok, frame_err, busy;

    biquad_coef_loader #(
        .N_SECT   (N),
        .COEF_ONE (16'h4000),
        .TIMEOUT  (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_0       (b_0),
        .b_1       (b_1),
        .b_2       (b_2),
        .a_1       (a_1),
        .a_2       (a_2),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             ok;
        logic [5*W-1:0]   coefs;
    } exp_t;

    exp_t          sb[$];
    logic [15:0]   m [N][5];   // model: section x {b0,b1,b2,a1,a2}
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic void chk(input string nm, input logic [5*W-1:0] act,
                                input logic [5*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] pack(input int f);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[16*k +: 16] = m[k][f];
        return r;
    endfunction

    function automatic logic [5*W-1:0] pack_all();
        return {pack(0), pack(1), pack(2), pack(3), pack(4)};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m[k][0] = 16'h4000;
            for (int f = 1; f < 5; f++) m[k][f] = 16'h0000;
        end
    endfunction

    // Monitor: pops one expectation per frame_ok/frame_err pulse; coefs may only move on frame_ok.
    initial begin
        logic [5*W-1:0] prev;
        logic [5*W-1:0] cur;
        logic           prev_pulse;
        exp_t           e;
        prev       = '0;
        prev_pulse = 1'b0;
        forever begin
            @(negedge CLK);
            cur = {b_0, b_1, b_2, a_1, a_2};
            if (RST) begin
                prev       = cur;
                prev_pulse = 1'b0;
            end else begin
                if (frame_ok && frame_err) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL both_pulses: got ok=1 err=1 want exclusive");
                end
                if (frame_ok || frame_err) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pulse: got ok=%b err=%b want none", frame_ok,
                                 frame_err);
                    end else begin
                        e = sb.pop_front();
                        chk1("pulse_kind_ok", frame_ok, e.ok);
                        chk("coefs_at_pulse", cur, e.coefs);
                    end
                    if (prev_pulse) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pulse_width: got 2+ cycles want 1");
                    end
                end
                if (!frame_ok) chk("coefs_hold", cur, prev);
                prev       = cur;
                prev_pulse = frame_ok || frame_err;
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 8) begin
            @(negedge CLK);
            guard++;
        end
        if (guard == 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_stuck: got 0 want 1 within 8 cycles");
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic gap(input int gmin, input int gmax);
        repeat ($urandom_range(gmax, gmin)) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] idx, input logic [7:0] cb [10],
                              input logic [7:0] chk_flip, input int gmin, input int gmax,
                              input int stall_at);
        logic [7:0] c;
        logic       ok;
        exp_t       e;
        c = idx;
        for (int i = 0; i < 10; i++) c = c ^ cb[i];
        c = c ^ chk_flip;
        send_byte(8'hA5);
        gap(gmin, gmax);
        send_byte(idx);
        gap(gmin, gmax);
        for (int i = 0; i < 10; i++) begin
            if (i == stall_at) begin
                e.ok    = 1'b0;
                e.coefs = pack_all();
                sb.push_back(e);
                repeat (TO) @(negedge CLK);
                chk1("timeout_err", frame_err, 1'b1);
                chk1("timeout_busy", busy, 1'b0);
                return;
            end
            send_byte(cb[i]);
            gap(gmin, gmax);
        end
        ok = (chk_flip == 8'h00) && (32'(idx) < N);
        if (ok) begin
            for (int f = 0; f < 5; f++) m[idx][f] = {cb[2*f], cb[2*f+1]};
        end
        e.ok    = ok;
        e.coefs = pack_all();
        sb.push_back(e);
        send_byte(c);
        // One cycle after CHK: commit cycle for good frames, error already flagged otherwise.
        chk1("post_chk_ready", in_ready, !ok);
        chk1("post_chk_busy", busy, ok);
    endtask

    initial begin
        logic [7:0] cb [10];
        logic [7:0] known [10];
        logic [7:0] flip;
        logic [7:0] idx;
        logic [7:0] j;

        #2_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cb [10];
        logic [7:0] known [10];
        logic [7:0] flip;
        logic [7:0] idx;
        logic [7:0] j;

        model_reset();
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_coefs", {b_0, b_1, b_2, a_1, a_2}, {{N{16'h4000}}, {(4*W){1'b0}}});
        chk1("reset_ready", in_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ok", frame_ok, 1'b0);
        chk1("reset_err", frame_err, 1'b0);

        known = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h10};
        send_frame(8'h01, known, 8'h00, 0, 0, -1);
        @(negedge CLK);
        chk1("known_ok", frame_ok, 1'b1);
        chk1("known_ready_back", in_ready, 1'b1);
        chk1("known_busy_low", busy, 1'b0);
        chk("known_sec1_b0", {{(4*W){1'b0}}, 48'h0, b_0[31:16]}, {{(4*W){1'b0}}, 48'h0, 16'h1234});
        chk("known_sec1_a1", {{(4*W){1'b0}}, 48'h0, a_1[31:16]}, {{(4*W){1'b0}}, 48'h0, 16'hFFFF});
        chk("known_sec1_a2", {{(4*W){1'b0}}, 48'h0, a_2[31:16]}, {{(4*W){1'b0}}, 48'h0, 16'h0010});
        chk("known_sec0_b0", {{(4*W){1'b0}}, 48'h0, b_0[15:0]}, {{(4*W){1'b0}}, 48'h0, 16'h4000});

        // Bad checksum, then out-of-range index with a correct checksum.
        send_frame(8'h01, known, 8'hFE, 0, 1, -1);
        send_frame(8'h04, known, 8'h00, 0, 1, -1);

        // Junk before a header, and 0xA5 used as payload data.
        send_byte(8'h00);
        send_byte(8'h7E);
        cb = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA5};
        send_frame(8'h03, cb, 8'h00, 0, 2, -1);

        // Longest legal gap between every byte must not abort.
        send_frame(8'h02, known, 8'h00, TO - 1, TO - 1, -1);

        // Stall after 5 coef bytes, then a full frame must still commit.
        for (int i = 0; i < 10; i++) cb[i] = 8'($urandom);
        send_frame(8'h00, cb, 8'h00, 0, 1, 5);
        send_frame(8'h00, cb, 8'h00, 0, 1, -1);

        // Asynchronous reset mid-frame after 3 coef bytes.
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        #2 RST = 1'b1;
        #1;
        chk("midrst_coefs", {b_0, b_1, b_2, a_1, a_2}, {{N{16'h4000}}, {(4*W){1'b0}}});
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_ready", in_ready, 1'b1);
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Randomized traffic: junk, bad checksums, bad indices, random gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j);
            end
            for (int i = 0; i < 10; i++) cb[i] = 8'($urandom);
            idx  = 8'($urandom_range(5, 0));
            flip = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(idx, cb, flip, 0, 3, -1);
        end

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", (5*W)'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
